regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Sequential read-out engine for the 32x32 register file; the reader counterpart of the regfile write port.
- On a start command it walks an inclusive address range through one register-file read port (rs1 or rs2 address/data pair).
- Each register value is captured and emitted as one beat on a valid/ready stream to debug/trace logic.
- Sits beside the regfile in the single-cycle core; its read-address output is muxed onto a read port while the core is halted.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset; synchronous, active-high despite the name. 1 = reset on the next rising edge.
- start_i  in  1  start request; sampled only in IDLE.
- first_addr_i  in  ADDR_W  first register of the range; sampled with start_i.
- last_addr_i  in  ADDR_W  last register of the range, inclusive; sampled with start_i.
- rf_addr_o  out  ADDR_W  address driven to a regfile read port (rs1_addr/rs2_addr).
- rf_data_i  in  DATA_W  combinational read data from that port (rs1_data/rs2_data).
- dump_valid_o  out  1  beat valid.
- dump_ready_i  in  1  sink ready.
- dump_data_o  out  DATA_W  captured register value.
- dump_addr_o  out  ADDR_W  register index of the beat.
- dump_last_o  out  1  beat is the final one of the range.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the range completes.

Behaviour:
- Reset values: state=IDLE. dump_valid_o, dump_last_o, busy_o and done_o = 0. rf_addr_o, dump_addr_o and dump_data_o = 0.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - If start_i=1: latch first into addr_q and last into last_q, then go to READ.
  - All other inputs are ignored.
- READ:
  - rf_addr_o=addr_q.
  - Register rf_data_i into data_q, then go to SEND.
  - Single cycle; the regfile read is combinational.
- SEND:
  - dump_valid_o=1, dump_data_o=data_q, dump_addr_o=addr_q, dump_last_o=(addr_q==last_q).
  - Outputs are held stable until dump_ready_i=1.
  - On handshake with addr_q==last_q: go to DONE.
  - On handshake otherwise: addr_q<=addr_q+1 (mod NUM_REGS), go to READ.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Throughput: 2 cycles per beat minimum (READ+SEND) with ready tied high.
- Latency: start accepted at cycle N → first dump_valid_o at cycle N+2. Last handshake at cycle M → done_o at M+1 → busy_o=0 at M+2.
- Wrap-around: if first>last, the range wraps 31→0 and continues to last. Example: 30,31,0,1 for first=30, last=1.
- first==last: exactly one beat, with dump_last_o=1.
- Full dump: first=0, last=31 gives 32 beats.
- Coherency: a beat carries the value read in its READ cycle. Later regfile writes do not alter a pending beat.
- start_i while busy_o=1: ignored; no restart, no queueing.
- Reset mid-operation: the next edge returns to IDLE. dump_valid_o drops and no done_o is issued.
- rf_addr_o holds its last value outside READ. The regfile ignores it because the read is side-effect free.

Optional Feature:
- Macro: REGFILE_DUMP_SKIP_X0_EN.
- Defined:
  - Address 0 is never emitted. In READ with addr_q==0, no capture and no SEND occur.
  - The end check (addr_q==last_q) is applied directly: go to DONE if it is true, else increment and stay in READ.
  - Range first=0, last=0 emits zero beats; done_o pulses 2 cycles after start.
  - dump_last_o asserts on the final emitted beat only.
  - If 0 is the last address, dump_last_o goes on the beat before it. That is address 31 in a wrapped range, or the last emitted address otherwise.
- Undefined: x0 is read and emitted like any other register (value 0 in a correct regfile).

Decomposition:
- Package regfile_dump_pkg:
  - ADDR_W and DATA_W localparams.
  - State enum typedef: IDLE, READ, SEND, DONE, 2-bit encoding.
  - Beat struct typedef: addr, data, last.
- No sub-module: a single FSM with an inline wrapping address counter. Splitting it out would add only a trivial counter.

Test Plan:
- Full dump, ready=1: regfile preloaded with reg[i]=i*0x11111111, start with 0..31 → 32 beats with addr 0..31 and matching data. last=1 on addr 31. done_o 1 cycle later. Total 65 cycles from start to done.
- Backpressure: range 4..6 with dump_ready_i low for 3 cycles on every beat → data/addr/last stable while stalled. Exactly 3 beats are emitted, none are lost or duplicated.
- Wrap and single-beat ranges:
  - first=30, last=1 → addr sequence 30,31,0,1; last only on addr 1.
  - first=last=7 → 1 beat with last=1.
- Coherency and restart:
  - Write reg5=0xDEADBEEF while the beat for reg5 is stalled in SEND → old value is emitted.
  - start_i pulsed mid-dump → ignored.
- Reset mid-dump: rst_ni=1 during SEND of beat 3 → next cycle valid=0 and busy=0, no done_o. A new start works normally.
- With REGFILE_DUMP_SKIP_X0_EN:
  - first=0, last=2 → beats addr 1,2 only.
  - first=0, last=0 → zero beats, done_o 2 cycles after start.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_pkg
// Shared types and sizes for the register-file read-out engine.
//   ADDR_W / DATA_W / NUM_REGS : register file geometry (NUM_REGS == 2**ADDR_W)
//   state_e                    : read-out FSM state encoding
//   beat_t                     : one stream beat (register index, value, last flag)
//   addr_inc()                 : wrapping register-index increment
// -----------------------------------------------------------------------------
package regfile_dump_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    // Next register index, wrapping from the top register back to x0.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (32'(a) == (NUM_REGS - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
// Walks an inclusive, possibly wrapping, register range through one regfile
// read port and emits each captured value as a beat on a valid/ready stream.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_ni         synchronous reset, active-high (1 = reset on next edge)
//   start_i        start request, only looked at while idle
//   first_addr_i   first register of the range (sampled with start_i)
//   last_addr_i    last register of the range, inclusive (sampled with start_i)
//   rf_addr_o      address to a regfile read port (rs1/rs2 address)
//   rf_data_i      combinational read data from that port
//   dump_valid_o   beat valid
//   dump_ready_i   sink ready
//   dump_data_o    captured register value
//   dump_addr_o    register index of the beat
//   dump_last_o    beat is the final one of the range
//   busy_o         engine not idle
//   done_o         one-cycle pulse when the range completes
//
// Build option:
//   REGFILE_DUMP_SKIP_X0_EN  when defined, register x0 is never emitted.
// -----------------------------------------------------------------------------
module regfile_dump
    import regfile_dump_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_rf_addr;
    beat_t             r_beat;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_at_last;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_last_beat;

    assign w_at_last  = (r_addr == r_last);
    assign w_addr_nxt = addr_inc(r_addr);

`ifdef REGFILE_DUMP_SKIP_X0_EN
    // When the range ends on x0 (never emitted), the beat just before it is the final one.
    assign w_last_beat = w_at_last || ((w_addr_nxt == '0) && (r_last == '0));
`else
    assign w_last_beat = w_at_last;
`endif

    // Read-out FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_last    <= '0;
            r_rf_addr <= '0;
            r_beat    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_addr    <= first_addr_i;
                        r_last    <= last_addr_i;
                        r_rf_addr <= first_addr_i;
                        r_busy    <= 1'b1;
                        r_state   <= READ;
                    end
                end

                READ: begin
`ifdef REGFILE_DUMP_SKIP_X0_EN
                    // x0 costs one READ cycle but produces no beat.
                    if (r_addr == '0) begin
                        if (w_at_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_addr    <= w_addr_nxt;
                            r_rf_addr <= w_addr_nxt;
                        end
                    end else
`endif
                    begin
                        // Capture now so later regfile writes cannot alter the pending beat.
                        r_beat.addr <= r_addr;
                        r_beat.data <= rf_data_i;
                        r_beat.last <= w_last_beat;
                        r_valid     <= 1'b1;
                        r_state     <= SEND;
                    end
                end

                SEND: begin
                    if (dump_ready_i) begin
                        r_valid <= 1'b0;
                        if (w_at_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_addr    <= w_addr_nxt;
                            r_rf_addr <= w_addr_nxt;
                            r_state   <= READ;
                        end
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rf_addr_o    = r_rf_addr;
    assign dump_valid_o = r_valid;
    assign dump_data_o  = r_beat.data;
    assign dump_addr_o  = r_beat.addr;
    assign dump_last_o  = r_beat.last;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
